// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared display-path types and constants for the DE0 7-segment chain.
// Used by bin_to_bcd_seq (optional macro BIN_TO_BCD_AUTO_CONVERT_EN lives in the top).
package de0_disp_pkg;

    localparam int DISP_DIGITS    = 4;
    localparam int DISP_BIN_WIDTH = 14;
    localparam int DISP_MAX       = 9999;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // 10^n, used to derive the largest value the digit count can show
    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 32'd1;
        for (int unsigned i = 32'd0; i < n; i++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between the binary source and the BCD converter.
interface bin_to_bcd_seq_if #(
    parameter int BIN_WIDTH = de0_disp_pkg::DISP_BIN_WIDTH,
    parameter int DIGITS    = de0_disp_pkg::DISP_DIGITS
) ();
    logic                   start;
    logic [BIN_WIDTH-1:0]   bin_in;
    logic                   busy;
    logic                   done;
    logic                   ovf;
    logic [4*DIGITS-1:0]    bcd_out;

    modport master (output start, bin_in, input busy, done, ovf, bcd_out);
    modport slave  (input start, bin_in, output busy, done, ovf, bcd_out);
endinterface

// File: rtl/bin_to_bcd_seq_adj.sv
// One-digit add-3 correction used ahead of each double-dabble shift.
module bcd_digit_adj
    import de0_disp_pkg::*;
(
    input  bcd_digit_t din,
    output bcd_digit_t dout
);

    // Digits of 5 or more would overflow past 9 after doubling
    always_comb begin
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter, one input bit per clk_50 cycle.
// Optional BIN_TO_BCD_AUTO_CONVERT_EN: self-start whenever bin_in changes while idle.
module bin_to_bcd_seq
    import de0_disp_pkg::*;
#(
    parameter int BIN_WIDTH = DISP_BIN_WIDTH,
    parameter int DIGITS    = DISP_DIGITS
) (
    input  logic              clk_50,
    input  logic              rst,
    bin_to_bcd_seq_if.slave   bus
);

    localparam int          BCD_W   = 4 * DIGITS;
    localparam int          CNT_W   = $clog2(BIN_WIDTH + 1);
    localparam logic [31:0] MAX_VAL = 32'(pow10(DIGITS) - 32'd1);

    state_t                   state_r,    state_nxt_s;
    logic [BIN_WIDTH-1:0]     shreg_r,    shreg_nxt_s;
    logic [BCD_W-1:0]         scratch_r,  scratch_nxt_s;
    logic [CNT_W-1:0]         cnt_r,      cnt_nxt_s;
    logic                     ovf_pend_r, ovf_pend_nxt_s;
    logic                     busy_r,     busy_nxt_s;
    logic                     done_r,     done_nxt_s;
    logic                     ovf_r,      ovf_nxt_s;
    logic [BCD_W-1:0]         bcd_r,      bcd_nxt_s;
    logic [BCD_W-1:0]         adj_s;
    logic [BCD_W+BIN_WIDTH-1:0] shifted_s;
    logic                     start_req_s;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch_r[4*g +: 4]),
            .dout (adj_s[4*g +: 4])
        );
    end

`ifdef BIN_TO_BCD_AUTO_CONVERT_EN
    logic [BIN_WIDTH-1:0] last_r;

    assign start_req_s = bus.start | (bus.bin_in != last_r);

    // Remember the operand of the last accepted conversion
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            last_r <= '0;
        end else if ((state_r == IDLE) && start_req_s) begin
            last_r <= bus.bin_in;
        end
    end
`else
    assign start_req_s = bus.start;
`endif

    assign shifted_s = {adj_s, shreg_r} << 1;

    // Next-state and datapath updates; results only move on the final shift
    always_comb begin
        state_nxt_s    = state_r;
        shreg_nxt_s    = shreg_r;
        scratch_nxt_s  = scratch_r;
        cnt_nxt_s      = cnt_r;
        ovf_pend_nxt_s = ovf_pend_r;
        busy_nxt_s     = busy_r;
        done_nxt_s     = 1'b0;
        ovf_nxt_s      = ovf_r;
        bcd_nxt_s      = bcd_r;
        case (state_r)
            IDLE: begin
                if (start_req_s) begin
                    shreg_nxt_s    = bus.bin_in;
                    scratch_nxt_s  = '0;
                    cnt_nxt_s      = '0;
                    ovf_pend_nxt_s = (32'(bus.bin_in) > MAX_VAL);
                    busy_nxt_s     = 1'b1;
                    state_nxt_s    = SHIFT;
                end else begin
                    state_nxt_s    = IDLE;
                end
            end
            SHIFT: begin
                scratch_nxt_s = shifted_s[BCD_W+BIN_WIDTH-1 -: BCD_W];
                shreg_nxt_s   = shifted_s[BIN_WIDTH-1:0];
                cnt_nxt_s     = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_r == CNT_W'(BIN_WIDTH - 1)) begin
                    bcd_nxt_s   = ovf_pend_r ? {DIGITS{4'h9}}
                                             : shifted_s[BCD_W+BIN_WIDTH-1 -: BCD_W];
                    ovf_nxt_s   = ovf_pend_r;
                    done_nxt_s  = 1'b1;
                    busy_nxt_s  = 1'b0;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            shreg_r    <= '0;
            scratch_r  <= '0;
            cnt_r      <= '0;
            ovf_pend_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            ovf_r      <= 1'b0;
            bcd_r      <= '0;
        end else begin
            state_r    <= state_nxt_s;
            shreg_r    <= shreg_nxt_s;
            scratch_r  <= scratch_nxt_s;
            cnt_r      <= cnt_nxt_s;
            ovf_pend_r <= ovf_pend_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
            ovf_r      <= ovf_nxt_s;
            bcd_r      <= bcd_nxt_s;
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.ovf     = ovf_r;
    assign bus.bcd_out = bcd_r;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: arithmetic reference model plus directed conversions.
module tb_bin_to_bcd_seq;
    import de0_disp_pkg::*;

    localparam int BW  = 14;
    localparam int LAT = BW;

    logic clk_50 = 1'b0;
    logic rst    = 1'b1;

    bin_to_bcd_seq_if #(.BIN_WIDTH(BW), .DIGITS(4)) bus ();

    bin_to_bcd_seq #(.BIN_WIDTH(BW), .DIGITS(4)) dut (
        .clk_50 (clk_50),
        .rst    (rst),
        .bus    (bus)
    );

    always #10 clk_50 = ~clk_50;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // reference model state
    logic        m_busy = 1'b0;
    int          m_rem  = 0;
    int          m_val  = 0;
    int          m_last = 0;
    logic        m_done = 1'b0;
    logic        m_ovf  = 1'b0;
    logic [15:0] m_bcd  = 16'h0000;
    logic        auto_trig;

`ifdef BIN_TO_BCD_AUTO_CONVERT_EN
    assign auto_trig = (int'(bus.bin_in) != m_last);
`else
    assign auto_trig = 1'b0;
`endif

    function automatic logic [15:0] dec_bcd(input int v);
        if (v > DISP_MAX) return 16'h9999;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: a conversion takes LAT edges after acceptance, result is decimal of the operand
    always @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_rem <= 0; m_val <= 0; m_last <= 0;
            m_done <= 1'b0; m_ovf <= 1'b0; m_bcd <= 16'h0000;
        end else begin
            cyc    <= cyc + 1;
            m_done <= 1'b0;
            if (m_busy) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_bcd  <= dec_bcd(m_val);
                    m_ovf  <= (m_val > DISP_MAX);
                end
            end else if (bus.start || auto_trig) begin
                m_busy <= 1'b1;
                m_rem  <= LAT;
                m_val  <= int'(bus.bin_in);
                m_last <= int'(bus.bin_in);
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(posedge clk_50) begin
        #1;
        if (!rst) begin
            check("cyc_done", 32'(bus.done), 32'(m_done));
            check("cyc_busy", 32'(bus.busy), 32'(m_busy));
            check("cyc_ovf",  32'(bus.ovf),  32'(m_ovf));
            check("cyc_bcd",  32'(bus.bcd_out), 32'(m_bcd));
        end
    end

    task automatic wait_done(input int limit, output logic seen);
        int i;
        i    = 0;
        seen = 1'b0;
        while (!seen && i < limit) begin
            @(posedge clk_50); #1;
            if (bus.done) seen = 1'b1;
            i++;
        end
    endtask

    task automatic conv(input int v, input logic [15:0] exp_bcd, input logic exp_ovf, input string nm);
        int   acc;
        logic seen;
        @(negedge clk_50); bus.bin_in = 14'(v); bus.start = 1'b1;
        @(posedge clk_50); #1; acc = cyc;
        @(negedge clk_50); bus.start = 1'b0;
        wait_done(40, seen);
        check({nm, "_seen"}, 32'(seen), 32'd1);
        check({nm, "_lat"},  32'(cyc - acc), 32'(LAT));
        check({nm, "_bcd"},  32'(bus.bcd_out), 32'(exp_bcd));
        check({nm, "_ovf"},  32'(bus.ovf), 32'(exp_ovf));
    endtask

    initial begin
        logic seen;
        int   d1;
        bus.start  = 1'b0;
        bus.bin_in = 14'd0;
        rst        = 1'b1;
        repeat (3) @(negedge clk_50);
        rst = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_bcd",  32'(bus.bcd_out), 32'h0000);

`ifdef BIN_TO_BCD_AUTO_CONVERT_EN
        repeat (3) @(negedge clk_50);
        bus.bin_in = 14'd255;
        wait_done(40, seen);
        check("auto_seen", 32'(seen), 32'd1);
        check("auto_bcd",  32'(bus.bcd_out), 32'h0255);
        wait_done(100, seen);
        check("auto_quiet", 32'(seen), 32'd0);
`else
        conv(1234,  16'h1234, 1'b0, "c1234");
        conv(0,     16'h0000, 1'b0, "c0");
        conv(9999,  16'h9999, 1'b0, "c9999");
        conv(12000, 16'h9999, 1'b1, "c12000");

        // ovf must survive the next start until that conversion finishes
        @(negedge clk_50); bus.bin_in = 14'd42; bus.start = 1'b1;
        @(posedge clk_50); #1;
        check("ovf_hold", 32'(bus.ovf), 32'd1);
        check("busy_42",  32'(bus.busy), 32'd1);
        @(negedge clk_50); bus.start = 1'b0;
        wait_done(40, seen);
        check("c42_bcd", 32'(bus.bcd_out), 32'h0042);
        check("c42_ovf", 32'(bus.ovf), 32'd0);

        // start held high, operand changes mid-flight, back-to-back re-accept
        @(negedge clk_50); bus.bin_in = 14'd5678; bus.start = 1'b1;
        @(negedge clk_50); bus.bin_in = 14'd1111;
        wait_done(40, seen);
        check("c5678_bcd", 32'(bus.bcd_out), 32'h5678);
        d1 = cyc;
        wait_done(40, seen);
        bus.start = 1'b0;
        check("c1111_bcd", 32'(bus.bcd_out), 32'h1111);
        check("b2b_gap",   32'(cyc - d1), 32'(LAT + 1));

        // async reset in the middle of a conversion
        @(negedge clk_50); bus.bin_in = 14'd4321; bus.start = 1'b1;
        @(negedge clk_50); bus.start = 1'b0;
        repeat (6) @(negedge clk_50);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_ovf",  32'(bus.ovf),  32'd0);
        check("mid_rst_bcd",  32'(bus.bcd_out), 32'h0000);
        repeat (2) @(negedge clk_50);
        rst = 1'b0;
        wait_done(20, seen);
        check("no_done_after_rst", 32'(seen), 32'd0);
        conv(4321, 16'h4321, 1'b0, "c4321");
`endif

        repeat (3) @(negedge clk_50);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential shift-and-add-3 (double-dabble) converter: unsigned binary in, packed BCD out.
Sits directly upstream of the 4-digit 7-segment driver and feeds its 16-bit value input, so the display shows decimal instead of hex.
One bit is processed per clock, which keeps the logic small on the DE0 clk_50 domain.
Output is held stable between conversions, so the downstream driver sees a value change only once per result.

Parameters:
BIN_WIDTH, 14, width of binary input; 14 covers 0..9999 plus an overflow range.
DIGITS, 4, number of BCD digits; bcd_out width = 4*DIGITS.

Ports:
clk_50  input  1  system clock, 50 MHz; all state on posedge.
rst  input  1  asynchronous, active-high reset.
start  input  1  conversion request, sampled on posedge while idle.
bin_in  input  BIN_WIDTH  unsigned binary operand, captured on the accepting edge.
busy  output  1  high while a conversion is in flight.
done  output  1  one-cycle pulse when bcd_out has just been updated.
ovf  output  1  high when the last accepted operand exceeded 10^DIGITS-1.
bcd_out  output  4*DIGITS  packed BCD result; digit 0 in [3:0]; held until the next done.

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, ovf=0, bcd_out=0, internal shift register and counter = 0. Applies immediately, including mid-conversion; the partial result is discarded.
- States: IDLE, SHIFT.
- IDLE, start=1 at edge E0:
  - latch bin_in into the shift register; clear the BCD scratch; cnt=0; busy=1; state=SHIFT.
  - compute overflow flag ovf_pend = (bin_in > 10^DIGITS-1).
- SHIFT, each edge:
  - every scratch digit >= 5 gets +3 (4-bit add, no carry out of a digit);
  - then shift {scratch, shreg} left by 1; cnt++.
- After the BIN_WIDTH-th SHIFT edge (edge E0+BIN_WIDTH):
  - bcd_out = scratch, or all 4'h9 digits if ovf_pend;
  - ovf = ovf_pend; done=1; busy=0; state=IDLE.
- Latency: done is high in the cycle after edge E0+BIN_WIDTH, i.e. 14 cycles after acceptance at default parameters.
- done is high for exactly one cycle. bcd_out and ovf are stable from that edge until the next done.
- start while busy=1: ignored, no queuing.
- start=1 in the done cycle: accepted (state is IDLE), so back-to-back conversions run every BIN_WIDTH+1 cycles.
- bin_in changing while busy: no effect on the result.
- ovf clears only on the next done (or reset), not on start.
- cnt width = clog2(BIN_WIDTH+1); scratch width = 4*DIGITS.

Optional Feature:
Macro BIN_TO_BCD_AUTO_CONVERT_EN.
- Defined: the block keeps a registered copy of the last accepted bin_in. In IDLE, if bin_in differs from that copy, it self-starts exactly as if start=1. The start port is still honoured. This gives a free-running display path without an external strobe, and conversion only happens on a change, which keeps downstream flicker-free.
- Undefined: no copy register; conversion happens only on start.

Decomposition:
- Package de0_disp_pkg:
  - typedef bcd_digit_t (4-bit);
  - constants DISP_DIGITS=4, DISP_BIN_WIDTH=14, DISP_MAX=9999;
  - state enum {IDLE, SHIFT}.
- Sub-module bcd_digit_adj: combinational, one digit; out = (in >= 5) ? in+3 : in. Instantiated DIGITS times in a generate loop.

Test Plan:
- rst pulse mid-stream, then release -> busy=0, done=0, ovf=0, bcd_out=16'h0000 immediately, asynchronously, before any clock edge.
- bin_in=1234, start 1 cycle -> done high exactly 14 cycles after the accept edge; bcd_out=16'h1234, ovf=0. Repeat with 0 -> 16'h0000 and 9999 -> 16'h9999.
- bin_in=12000, start -> bcd_out=16'h9999, ovf=1. Then bin_in=42, start -> ovf stays 1 until that done, then bcd_out=16'h0042, ovf=0.
- start at accept, hold start high and change bin_in 5678->1111 during busy -> single result 16'h5678. Re-acceptance occurs in the done cycle, giving 16'h1111 15 cycles later.
- rst asserted at SHIFT cycle 7 of a 4321 conversion -> no done pulse, bcd_out=0. A fresh start afterwards -> 16'h4321.
- With BIN_TO_BCD_AUTO_CONVERT_EN, start tied 0: bin_in 0->255 -> one conversion, 16'h0255. bin_in held -> no further done pulses over 100 cycles.
